// File: rtl/ysyx_22040386_alu_pkg.sv
// ysyx_22040386_alu_pkg: ALUop codes, ALUctr codes, dispatcher states and decode helpers.
package ysyx_22040386_alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_I   = 3'b001;
  localparam logic [2:0] OP_R   = 3'b010;
  localparam logic [2:0] OP_B   = 3'b011;
  localparam logic [2:0] OP_IW  = 3'b100;
  localparam logic [2:0] OP_RW  = 3'b101;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;
  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_SUB    = 6'b100000;
  localparam logic [5:0] ALU_AND    = 6'b000001;
  localparam logic [5:0] ALU_OR     = 6'b000010;
  localparam logic [5:0] ALU_XOR    = 6'b000011;
  localparam logic [5:0] ALU_SLL    = 6'b000100;
  localparam logic [5:0] ALU_SRL    = 6'b000101;
  localparam logic [5:0] ALU_SRA    = 6'b100110;
  localparam logic [5:0] ALU_SLTU   = 6'b100111;
  localparam logic [5:0] ALU_SLT    = 6'b110111;
  localparam logic [5:0] ALU_MUL    = 6'b001000;
  localparam logic [5:0] ALU_DIV    = 6'b001001;
  localparam logic [5:0] ALU_REM    = 6'b001100;
  localparam logic [5:0] ALU_MULH   = 6'b001010;
  localparam logic [5:0] ALU_MULHSU = 6'b001011;
  localparam logic [5:0] ALU_MULHU  = 6'b001101;
  localparam logic [5:0] ALU_DIVU   = 6'b001110;
  localparam logic [5:0] ALU_REMU   = 6'b001111;
  typedef enum logic [1:0] {S_IDLE, S_VALID, S_WAIT} state_e;
  function automatic logic [5:0] base_ctr(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [5:0] mul_ctr(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction
endpackage

// File: rtl/ysyx_22040386_alu_decode.sv
// ysyx_22040386_alu_decode: combinational ALUop/funct3/funct7 decode into ALUctr.
// M-extension decode is enabled by YSYX_22040386_ALU_MEXT_EN.
module ysyx_22040386_alu_decode
  import ysyx_22040386_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [5:0] alu_ctr,
  output logic       word,
  output logic       mext,
  output logic       illegal,
  output logic       is_div
);
`ifdef YSYX_22040386_ALU_MEXT_EN
  localparam bit MEXT_EN = 1'b1;
`else
  localparam bit MEXT_EN = 1'b0;
`endif
  localparam bit RV64 = XLEN == 64;
  logic [5:0] ctr;
  logic       ok, w, sh_base, sh_alt, f7_m;
  always_comb begin
    ctr = ALU_ADD;
    ok = 1'b1;
    w = 1'b0;
    sh_base = RV64 ? funct7[6:1] == 6'b000000 : funct7 == F7_BASE;
    sh_alt = RV64 ? funct7[6:1] == 6'b010000 : funct7 == F7_ALT;
    f7_m = MEXT_EN && funct7 == F7_M;
    case (alu_op)
      OP_ADD: ctr = ALU_ADD;
      OP_I: begin
        ctr = funct3 == 3'b101 && sh_alt ? ALU_SRA : base_ctr(funct3);
        ok = funct3 == 3'b001 ? sh_base : funct3 == 3'b101 ? sh_base || sh_alt : 1'b1;
      end
      OP_R: begin
        ctr = funct7 == F7_ALT ? (funct3 == 3'b000 ? ALU_SUB : ALU_SRA) :
              f7_m ? mul_ctr(funct3) : base_ctr(funct3);
        ok = funct7 == F7_BASE || f7_m || (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_B: begin
        ctr = funct3[2:1] == 2'b00 ? ALU_SUB : funct3[1] ? ALU_SLTU : ALU_SLT;
        ok = funct3[2:1] != 2'b01;
      end
      OP_IW: begin
        w = 1'b1;
        ctr = funct3 == 3'b101 && funct7 == F7_ALT ? ALU_SRA : base_ctr(funct3);
        ok = RV64 && (funct3 == 3'b000 || (funct3 == 3'b001 && funct7 == F7_BASE) ||
             (funct3 == 3'b101 && (funct7 == F7_BASE || funct7 == F7_ALT)));
      end
      OP_RW: begin
        w = 1'b1;
        ctr = funct7 == F7_ALT ? (funct3 == 3'b000 ? ALU_SUB : ALU_SRA) :
              f7_m ? mul_ctr(funct3) : base_ctr(funct3);
        ok = RV64 && (
             (funct7 == F7_BASE && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) ||
             (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) ||
             (f7_m && (funct3 == 3'b000 || funct3[2])));
      end
      default: ok = 1'b0;
    endcase
    alu_ctr = ok ? ctr : ALU_ADD;
    word = ok && w;
    illegal = !ok;
    mext = ok && ctr[5:3] == 3'b001;
    is_div = ok && ctr inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  end
endmodule

// File: rtl/ysyx_22040386_alu_dispatch.sv
// ysyx_22040386_alu_dispatch: registered ALU-control dispatcher with valid/ready and M-op latency hold.
// YSYX_22040386_ALU_MEXT_EN enables mul/div/rem decode and the multi-cycle WAIT state.
module ysyx_22040386_alu_dispatch
  import ysyx_22040386_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] alu_ctr,
  output logic       out_word,
  output logic       out_mext,
  output logic       illegal,
  output logic       busy
);
  logic [5:0] dec_ctr, ctr_q, ctr_d;
  logic       dec_word, dec_mext, dec_illegal, dec_is_div, accept;
  logic       word_q, word_d, mext_q, mext_d, ill_q, ill_d;
  state_e     state_q, state_d;
  ysyx_22040386_alu_decode #(.XLEN(XLEN)) u_decode (
    .alu_op (alu_op),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_ctr(dec_ctr),
    .word   (dec_word),
    .mext   (dec_mext),
    .illegal(dec_illegal),
    .is_div (dec_is_div)
  );
  assign in_ready = !flush && (state_q == S_IDLE || (state_q == S_VALID && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state_q == S_VALID;
  assign alu_ctr = ctr_q;
  assign out_word = word_q;
  assign out_mext = mext_q;
  assign illegal = ill_q;
`ifdef YSYX_22040386_ALU_MEXT_EN
  localparam int CW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);
  logic [CW-1:0] cnt_q, cnt_d, lat_m1;
  assign busy = state_q == S_WAIT;
`else
  assign busy = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ctr_d = ctr_q;
    word_d = word_q;
    mext_d = mext_q;
    ill_d = ill_q;
`ifdef YSYX_22040386_ALU_MEXT_EN
    cnt_d = cnt_q;
    lat_m1 = dec_is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == CW'(1) ? S_VALID : S_WAIT;
    end
`endif
    if (state_q == S_VALID && out_ready) state_d = S_IDLE;
    if (accept) begin
      {ctr_d, word_d, mext_d, ill_d} = {dec_ctr, dec_word, dec_mext, dec_illegal};
      state_d = S_VALID;
`ifdef YSYX_22040386_ALU_MEXT_EN
      // LAT==1 units complete like ordinary ops
      if (dec_mext && lat_m1 != '0) begin
        state_d = S_WAIT;
        cnt_d = lat_m1;
      end
`endif
    end
    if (flush) begin
      state_d = S_IDLE;
      {ctr_d, word_d, mext_d, ill_d} = '0;
`ifdef YSYX_22040386_ALU_MEXT_EN
      cnt_d = '0;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      {ctr_q, word_q, mext_q, ill_q} <= '0;
`ifdef YSYX_22040386_ALU_MEXT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      {ctr_q, word_q, mext_q, ill_q} <= {ctr_d, word_d, mext_d, ill_d};
`ifdef YSYX_22040386_ALU_MEXT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_ysyx_22040386_alu_dispatch.sv
// tb_ysyx_22040386_alu_dispatch: scoreboard bench for the ALU dispatcher (32-bit main DUT, 64-bit side DUT).
module tb_ysyx_22040386_alu_dispatch;
`ifdef YSYX_22040386_ALU_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;
  typedef struct packed {
    logic [5:0] ctr;
    logic       word;
    logic       mext;
    logic       illegal;
    int         lat;
    int         due;
  } exp_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1, in_valid64 = 0;
  logic [2:0] alu_op = 0, funct3 = 0;
  logic [6:0] funct7 = 0;
  logic in_ready, out_valid, out_word, out_mext, illegal, busy;
  logic [5:0] alu_ctr;
  logic in_ready64, out_valid64, out_word64, out_mext64, illegal64, busy64;
  logic [5:0] alu_ctr64;
  int checks = 0, failures = 0, cyc = 0;
  bit seen = 0;
  exp_t sb[$];
  exp_t me;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ysyx_22040386_alu_dispatch #(.XLEN(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctr(alu_ctr), .out_word(out_word), .out_mext(out_mext),
    .illegal(illegal), .busy(busy)
  );
  ysyx_22040386_alu_dispatch #(.XLEN(64), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut64 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid64), .in_ready(in_ready64),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .out_valid(out_valid64),
    .out_ready(1'b1), .alu_ctr(alu_ctr64), .out_word(out_word64), .out_mext(out_mext64),
    .illegal(illegal64), .busy(busy64)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic exp_t model(input int xlen, input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
    exp_t e;
    logic ok, w, rv64, m, sz, sa;
    logic [5:0] c;
    rv64 = xlen == 64;
    m = MEXT && f7 == 7'b0000001;
    sz = rv64 ? f7[6:1] == 6'b0 : f7 == 7'b0;
    sa = rv64 ? f7[6:1] == 6'b010000 : f7 == 7'b0100000;
    ok = 1'b0; w = 1'b0; c = 6'b000000;
    case (op)
      3'b000: ok = 1'b1;
      3'b001: case (f3)
        3'b000: ok = 1'b1;
        3'b010: begin c = 6'b110111; ok = 1'b1; end
        3'b011: begin c = 6'b100111; ok = 1'b1; end
        3'b100: begin c = 6'b000011; ok = 1'b1; end
        3'b110: begin c = 6'b000010; ok = 1'b1; end
        3'b111: begin c = 6'b000001; ok = 1'b1; end
        3'b001: begin c = 6'b000100; ok = sz; end
        default: begin c = sz ? 6'b000101 : 6'b100110; ok = sz || sa; end
      endcase
      3'b010: begin
        ok = 1'b1;
        if (f7 == 7'b0) c = f3 == 0 ? 6'b000000 : f3 == 1 ? 6'b000100 : f3 == 2 ? 6'b110111 : f3 == 3 ? 6'b100111 :
                            f3 == 4 ? 6'b000011 : f3 == 5 ? 6'b000101 : f3 == 6 ? 6'b000010 : 6'b000001;
        else if (f7 == 7'b0100000 && f3 == 0) c = 6'b100000;
        else if (f7 == 7'b0100000 && f3 == 5) c = 6'b100110;
        else if (m) c = f3 == 0 ? 6'b001000 : f3 == 1 ? 6'b001010 : f3 == 2 ? 6'b001011 : f3 == 3 ? 6'b001101 :
                        f3 == 4 ? 6'b001001 : f3 == 5 ? 6'b001110 : f3 == 6 ? 6'b001100 : 6'b001111;
        else ok = 1'b0;
      end
      3'b011: begin
        ok = f3 != 2 && f3 != 3;
        c = f3 < 2 ? 6'b100000 : f3 < 6 ? 6'b110111 : 6'b100111;
      end
      3'b100: if (rv64) begin
        w = 1'b1;
        if (f3 == 0) begin c = 6'b000000; ok = 1'b1; end
        else if (f3 == 1 && f7 == 0) begin c = 6'b000100; ok = 1'b1; end
        else if (f3 == 5 && f7 == 0) begin c = 6'b000101; ok = 1'b1; end
        else if (f3 == 5 && f7 == 7'b0100000) begin c = 6'b100110; ok = 1'b1; end
      end
      3'b101: if (rv64) begin
        w = 1'b1;
        ok = 1'b1;
        if (f7 == 0 && f3 == 0) c = 6'b000000;
        else if (f7 == 0 && f3 == 1) c = 6'b000100;
        else if (f7 == 0 && f3 == 5) c = 6'b000101;
        else if (f7 == 7'b0100000 && f3 == 0) c = 6'b100000;
        else if (f7 == 7'b0100000 && f3 == 5) c = 6'b100110;
        else if (m && f3 == 0) c = 6'b001000;
        else if (m && f3 == 4) c = 6'b001001;
        else if (m && f3 == 5) c = 6'b001110;
        else if (m && f3 == 6) c = 6'b001100;
        else if (m && f3 == 7) c = 6'b001111;
        else ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    e.ctr = ok ? c : 6'b0;
    e.word = ok && w;
    e.illegal = !ok;
    e.mext = ok && (e.ctr inside {6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111});
    e.lat = !e.mext ? 1 : (e.ctr inside {6'b001001, 6'b001110, 6'b001100, 6'b001111}) ? DIV_LAT : MUL_LAT;
    e.due = 0;
    return e;
  endfunction
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        if (!seen) begin
          check("latency", cyc, sb[0].due);
          seen = 1;
        end
        if (out_ready) begin
          me = sb.pop_front();
          seen = 0;
          check("alu_ctr", alu_ctr, me.ctr);
          check("out_word", out_word, me.word);
          check("out_mext", out_mext, me.mext);
          check("illegal", illegal, me.illegal);
        end
      end
    end
  end
  task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
    exp_t e;
    int i;
    e = model(32, op, f3, f7);
    alu_op = op; funct3 = f3; funct7 = f7; in_valid = 1;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    e.due = cyc + e.lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic check64(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
    exp_t e;
    e = model(64, op, f3, f7);
    alu_op = op; funct3 = f3; funct7 = f7; in_valid64 = 1;
    @(negedge clk);
    check("in_ready64", in_ready64, 1);
    @(posedge clk);
    #1 in_valid64 = 0;
    @(negedge clk);
    check("out_valid64", out_valid64, 1);
    check("alu_ctr64", alu_ctr64, e.ctr);
    check("out_word64", out_word64, e.word);
    check("illegal64", illegal64, e.illegal);
    @(posedge clk);
    #1;
  endtask
  logic [12:0] tbl[] = '{
    {3'b000, 3'b111, 7'b1111111}, {3'b001, 3'b001, 7'b0000000}, {3'b001, 3'b001, 7'b0000001},
    {3'b001, 3'b101, 7'b0100000}, {3'b001, 3'b101, 7'b0100001}, {3'b001, 3'b011, 7'b1010101},
    {3'b001, 3'b111, 7'b0110011}, {3'b011, 3'b000, 7'b0000000}, {3'b011, 3'b101, 7'b0000000},
    {3'b011, 3'b111, 7'b0000000}, {3'b011, 3'b010, 7'b0000000}, {3'b010, 3'b001, 7'b0000000},
    {3'b010, 3'b001, 7'b0100000}, {3'b010, 3'b000, 7'b0000001}, {3'b010, 3'b011, 7'b0000001},
    {3'b010, 3'b111, 7'b0000001}, {3'b110, 3'b000, 7'b0000000}, {3'b111, 3'b000, 7'b0000000},
    {3'b101, 3'b000, 7'b0000000}, {3'b100, 3'b000, 7'b0000000}, {3'b101, 3'b101, 7'b0100000}
  };
  initial begin
    int c0;
    logic [12:0] t;
    logic [6:0] f7s[4];
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_ctr", alu_ctr, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    c0 = cyc;
    send(3'b010, 3'b000, 7'b0100000);
    send(3'b010, 3'b110, 7'b0000000);
    send(3'b010, 3'b100, 7'b0000000);
    send(3'b010, 3'b010, 7'b0000000);
    check("no_bubble", cyc - c0, 4);
    idle();
    drain();
    foreach (tbl[i]) begin
      t = tbl[i];
      send(t[12:10], t[9:7], t[6:0]);
    end
    idle();
    drain();
    send(3'b010, 3'b100, 7'b0000001);
    idle();
    for (int i = 1; i <= DIV_LAT; i++) begin
      @(negedge clk);
      check("div_busy", busy, (MEXT && i < DIV_LAT) ? 1 : 0);
      check("div_in_ready", in_ready, (MEXT && i < DIV_LAT) ? 0 : 1);
      check("div_out_valid", out_valid, (i == (MEXT ? DIV_LAT : 1)) ? 1 : 0);
    end
    drain();
    send(3'b010, 3'b000, 7'b0000001);
    idle();
    @(posedge clk);
    #1;
    flush = 1; in_valid = 1; alu_op = 3'b000; funct3 = 3'b000; funct7 = 7'b0;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 0; in_valid = 0;
    sb.delete();
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("flush_out_valid", out_valid, 0);
      check("flush_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    send(3'b010, 3'b111, 7'b0000000);
    idle();
    drain();
    check64(3'b101, 3'b101, 7'b0100000);
    check64(3'b100, 3'b000, 7'b1111111);
    check64(3'b100, 3'b101, 7'b0100000);
    check64(3'b001, 3'b001, 7'b0000001);
    check64(3'b101, 3'b101, 7'b0000010);
    check64(3'b110, 3'b000, 7'b0000000);
    send(3'b101, 3'b101, 7'b0100000);
    idle();
    drain();
    out_ready = 0;
    send(3'b010, 3'b100, 7'b0000000);
    idle();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_alu_ctr", alu_ctr, 6'b000011);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1;
    drain();
    f7s = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b0000000};
    for (int i = 0; i < 30; i++) begin
      f7s[3] = 7'($urandom);
      send(3'($urandom), 3'($urandom), f7s[$urandom_range(0, 3)]);
      if (i % 3 == 0) idle();
    end
    idle();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
